// File: rtl/key_press_if.sv
// Command/status bundle between a key-press stimulus generator and its controller.
// Handshake: start is honoured only while busy=0, and the accepting edge raises busy.
// done pulses for one cycle when a sequence ends, whether it completed or was aborted.
interface key_press_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] num;
  logic             bounce_en;
  logic             abort;
  logic             key_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent;

  modport master (
    output start, num, bounce_en, abort,
    input  key_out, busy, done, sent
  );

  modport slave (
    input  start, num, bounce_en, abort,
    output key_out, busy, done, sent
  );
endinterface

// File: rtl/key_press_gen.sv
// Generates active-low mechanical key waveforms (optional bounce, hold, release)
// for a requested number of presses, with a start/busy/done handshake.
module key_press_gen #(
  parameter int HOLD_CYC = 24,
  parameter int REL_CYC  = 16,
  parameter int BOUNCE_N = 3,
  parameter int BOUNCE_W = 2,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  key_press_if.slave bus,
  output logic [2:0] state_dbg
);

  localparam int PH_MAX_A = (HOLD_CYC > REL_CYC) ? HOLD_CYC : REL_CYC;
  localparam int PH_MAX   = (PH_MAX_A > BOUNCE_W) ? PH_MAX_A : BOUNCE_W;
  localparam int PH_W     = $clog2(PH_MAX + 1);
  localparam int PAIR_W   = $clog2(BOUNCE_N + 1);

  typedef enum logic [2:0] {IDLE, BNC_DN, HOLD, BNC_UP, REL} state_t;

  state_t            state_q, state_nxt;
  logic [PH_W-1:0]   phase_q, phase_nxt;
  logic              half_q, half_nxt;
  logic [PAIR_W-1:0] pair_q, pair_nxt;
  logic [CNT_W-1:0]  sent_q, sent_nxt, sent_inc;
  logic [CNT_W-1:0]  num_q, num_nxt;
  logic              bnc_q, bnc_nxt;
  logic              key_q, key_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;

  assign sent_inc = sent_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      half_q  <= 1'b0;
      pair_q  <= '0;
      sent_q  <= '0;
      num_q   <= '0;
      bnc_q   <= 1'b0;
      key_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      phase_q <= phase_nxt;
      half_q  <= half_nxt;
      pair_q  <= pair_nxt;
      sent_q  <= sent_nxt;
      num_q   <= num_nxt;
      bnc_q   <= bnc_nxt;
      key_q   <= key_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    phase_nxt = phase_q;
    half_nxt  = half_q;
    pair_nxt  = pair_q;
    sent_nxt  = sent_q;
    num_nxt   = num_q;
    bnc_nxt   = bnc_q;
    done_nxt  = 1'b0;
    if (state_q == IDLE) begin
      if (bus.start) begin
        if (bus.num != '0) begin
          num_nxt   = bus.num;
          bnc_nxt   = bus.bounce_en;
          sent_nxt  = '0;
          phase_nxt = '0;
          half_nxt  = 1'b0;
          pair_nxt  = '0;
          state_nxt = bus.bounce_en ? BNC_DN : HOLD;
        end else begin
          done_nxt = 1'b1;
        end
      end
    end else if (bus.abort) begin
      // Partial press is discarded: sent keeps its last completed count.
      state_nxt = IDLE;
      done_nxt  = 1'b1;
      phase_nxt = '0;
      half_nxt  = 1'b0;
      pair_nxt  = '0;
    end else begin
      unique case (state_q)
        BNC_DN, BNC_UP: begin
          if (phase_q == PH_W'(BOUNCE_W - 1)) begin
            phase_nxt = '0;
            half_nxt  = ~half_q;
            if (half_q) begin
              if (pair_q == PAIR_W'(BOUNCE_N - 1)) begin
                pair_nxt  = '0;
                state_nxt = (state_q == BNC_DN) ? HOLD : REL;
              end else begin
                pair_nxt = pair_q + PAIR_W'(1);
              end
            end
          end else begin
            phase_nxt = phase_q + PH_W'(1);
          end
        end
        HOLD: begin
          if (phase_q == PH_W'(HOLD_CYC - 1)) begin
            phase_nxt = '0;
            state_nxt = bnc_q ? BNC_UP : REL;
          end else begin
            phase_nxt = phase_q + PH_W'(1);
          end
        end
        REL: begin
          if (phase_q == PH_W'(REL_CYC - 1)) begin
            phase_nxt = '0;
            sent_nxt  = sent_inc;
            if (sent_inc == num_q) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = bnc_q ? BNC_DN : HOLD;
            end
          end else begin
            phase_nxt = phase_q + PH_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Key level is a function of the upcoming state so it lands with the state change.
  always_comb begin
    key_nxt  = 1'b1;
    busy_nxt = (state_nxt != IDLE);
    case (state_nxt)
      BNC_DN:  key_nxt = half_nxt;
      HOLD:    key_nxt = 1'b0;
      BNC_UP:  key_nxt = ~half_nxt;
      default: key_nxt = 1'b1;
    endcase
  end

  assign bus.key_out = key_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sent    = sent_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_key_press_gen.sv
// Directed bench for key_press_gen: waveform shape, handshake, abort, reset.
module tb_key_press_gen;

  logic       clk;
  logic       rst;
  logic [2:0] state_dbg;
  int         checks;
  int         failures;

  key_press_if #(.CNT_W(4)) kp ();

  key_press_gen dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (kp),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected key level for cycle i of a sequence with default parameters.
  function automatic logic key_exp(input int i, input bit be);
    int j;
    if (!be) begin
      j = i % 40;
      return (j < 24) ? 1'b0 : 1'b1;
    end
    j = i % 64;
    if (j < 12) return ((j / 2) % 2 == 0) ? 1'b0 : 1'b1;
    if (j < 36) return 1'b0;
    if (j < 48) return (((j - 36) / 2) % 2 == 0) ? 1'b1 : 1'b0;
    return 1'b1;
  endfunction

  task automatic launch(input logic [3:0] n, input bit be);
    @(negedge clk);
    kp.start     = 1'b1;
    kp.num       = n;
    kp.bounce_en = be;
  endtask

  task automatic run_seq(input int n_samples, input bit be, input int abort_at, input int pulse_at);
    int period;
    period = be ? 64 : 40;
    for (int i = 0; i < n_samples; i++) begin
      @(negedge clk);
      check($sformatf("key[%0d]", i), kp.key_out, key_exp(i, be));
      check($sformatf("busy[%0d]", i), kp.busy, 1);
      check($sformatf("done[%0d]", i), kp.done, 0);
      check($sformatf("sent[%0d]", i), kp.sent, i / period);
      kp.start = (i == pulse_at);
      if (i == pulse_at) begin
        kp.num       = 4'd7;
        kp.bounce_en = 1'b1;
      end
      kp.abort = (i == abort_at);
    end
  endtask

  task automatic check_done(input string tag, input int exp_sent);
    @(negedge clk);
    check({tag, "_done"}, kp.done, 1);
    check({tag, "_busy"}, kp.busy, 0);
    check({tag, "_key"}, kp.key_out, 1);
    check({tag, "_sent"}, kp.sent, exp_sent);
  endtask

  task automatic check_quiet(input string tag, input int exp_sent);
    @(negedge clk);
    check({tag, "_done0"}, kp.done, 0);
    check({tag, "_busy0"}, kp.busy, 0);
    check({tag, "_key1"}, kp.key_out, 1);
    check({tag, "_sent_hold"}, kp.sent, exp_sent);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    kp.start     = 1'b0;
    kp.num       = '0;
    kp.bounce_en = 1'b0;
    kp.abort     = 1'b0;

    @(negedge clk);
    check("rst_key", kp.key_out, 1);
    check("rst_busy", kp.busy, 0);
    check("rst_done", kp.done, 0);
    check("rst_sent", kp.sent, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;

    // Three plain presses.
    launch(4'd3, 1'b0);
    run_seq(120, 1'b0, -1, -1);
    check_done("plain3", 3);
    check_quiet("plain3", 3);

    // Abort is ignored while idle.
    @(negedge clk);
    kp.abort = 1'b1;
    check_quiet("idle_abort", 3);
    kp.abort = 1'b0;

    // One press with bounce on both edges.
    launch(4'd1, 1'b1);
    run_seq(64, 1'b1, -1, -1);
    check_done("bounce1", 1);
    check_quiet("bounce1", 1);

    // Asynchronous reset in the middle of the second press hold.
    launch(4'd2, 1'b0);
    run_seq(46, 1'b0, -1, -1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_key", kp.key_out, 1);
    check("mid_rst_busy", kp.busy, 0);
    check("mid_rst_done", kp.done, 0);
    check("mid_rst_sent", kp.sent, 0);
    check("mid_rst_state", state_dbg, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_key", kp.key_out, 1);
    check("post_rst_busy", kp.busy, 0);
    check("post_rst_state", state_dbg, 0);

    // num=0 produces only a done pulse.
    launch(4'd0, 1'b0);
    @(negedge clk);
    kp.start = 1'b0;
    check("zero_done", kp.done, 1);
    check("zero_busy", kp.busy, 0);
    check("zero_key", kp.key_out, 1);
    check("zero_sent", kp.sent, 0);
    check_quiet("zero", 0);

    // Abort in the 10th cycle of the second press hold.
    launch(4'd5, 1'b0);
    run_seq(50, 1'b0, 49, -1);
    check_done("abort", 1);
    kp.abort = 1'b0;
    check_quiet("abort", 1);

    // Start while busy is ignored; start in the done cycle is accepted.
    launch(4'd2, 1'b0);
    run_seq(80, 1'b0, -1, 10);
    check_done("busy_start", 2);
    kp.start     = 1'b1;
    kp.num       = 4'd1;
    kp.bounce_en = 1'b0;
    run_seq(40, 1'b0, -1, -1);
    check_done("done_start", 1);
    check_quiet("done_start", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
